// File: rtl/cfu_simd_mac.sv
// cfu_simd_mac: CFU-port unit performing packed 4-lane int8 multiply-accumulate
// with a programmable input offset into a bank of 32-bit accumulators.
// One command is outstanding at a time: IDLE accepts, BUSY covers the MAC
// pipeline depth, RESP holds the registered response until the CPU takes it.
module cfu_simd_mac #(
  parameter int NUM_ACC    = 4,
  parameter int MAC_STAGES = 2,
  parameter int OFFSET_W   = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_payload_outputs_0
);

  // At least one index bit so a single-bank build still has a legal array.
  localparam int BANK_W = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;
  localparam int ACC_N  = 1 << BANK_W;
  localparam logic [2:0] CNT_INIT = 3'(MAC_STAGES);

  localparam logic [6:0] OP_ECHO       = 7'd0;
  localparam logic [6:0] OP_SET_OFFSET = 7'd1;
  localparam logic [6:0] OP_CLEAR      = 7'd2;
  localparam logic [6:0] OP_MAC        = 7'd3;
  localparam logic [6:0] OP_READ       = 7'd4;
  localparam logic [6:0] OP_SET_ACC    = 7'd5;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t                      state_q;
  logic [2:0]                  cnt_q;
  logic [BANK_W-1:0]           bank_q;
  logic [31:0]                 a_q;
  logic [31:0]                 b_q;
  logic signed [OFFSET_W-1:0]  offset_q;
  logic [31:0]                 acc_q [ACC_N];
  logic                        rsp_valid_q;
  logic                        cmd_ready_q;
  logic [31:0]                 rsp_data_q;

  logic [6:0]                  cmd_funct7;
  logic [2:0]                  cmd_funct3;
  logic [BANK_W-1:0]           cmd_bank_d;
  logic signed [16:0]          lane_prod [4];
  logic signed [18:0]          lane_sum_d;
  logic [31:0]                 mac_acc_d;

  assign cmd_funct7 = cmd_payload_function_id[9:3];
  assign cmd_funct3 = cmd_payload_function_id[2:0];
  // Bank count is a power of two, so the modulo reduces to the low index bits.
  assign cmd_bank_d = BANK_W'(32'(cmd_funct3) % NUM_ACC);

  // Per-lane offset-adjusted activation times weight, from operands latched at accept.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic signed [8:0] a_lane;
    logic signed [7:0] b_lane;
    assign a_lane = 9'(32'($signed(a_q[8*gi +: 8])) + 32'(offset_q));
    assign b_lane = b_q[8*gi +: 8];
    assign lane_prod[gi] = 17'(a_lane) * 17'(b_lane);
  end

  // Lane reduction, sign-extended and added to the selected bank with plain wrap.
  always_comb begin
    lane_sum_d = 19'(lane_prod[0]) + 19'(lane_prod[1])
               + 19'(lane_prod[2]) + 19'(lane_prod[3]);
    mac_acc_d  = acc_q[bank_q] + 32'(lane_sum_d);
  end

  // Command FSM with registered handshake outputs and accumulator bank updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bank_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      offset_q    <= '0;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_data_q  <= '0;
      for (int i = 0; i < ACC_N; i++) acc_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            bank_q      <= cmd_bank_d;
            cmd_ready_q <= 1'b0;
            if (cmd_funct7 == OP_MAC) begin
              a_q     <= cmd_payload_inputs_0;
              b_q     <= cmd_payload_inputs_1;
              cnt_q   <= CNT_INIT;
              state_q <= S_BUSY;
            end else begin
              rsp_valid_q <= 1'b1;
              state_q     <= S_RESP;
              case (cmd_funct7)
                OP_ECHO: rsp_data_q <= cmd_payload_inputs_0;
                OP_SET_OFFSET: begin
                  offset_q   <= cmd_payload_inputs_0[OFFSET_W-1:0];
                  rsp_data_q <= '0;
                end
                OP_CLEAR: begin
                  rsp_data_q         <= acc_q[cmd_bank_d];
                  acc_q[cmd_bank_d]  <= '0;
                end
                OP_READ: rsp_data_q <= acc_q[cmd_bank_d];
                OP_SET_ACC: begin
                  acc_q[cmd_bank_d] <= cmd_payload_inputs_0;
                  rsp_data_q        <= cmd_payload_inputs_0;
                end
                default: rsp_data_q <= '0;
              endcase
            end
          end
        end
        S_BUSY: begin
          // The last counted cycle retires the MAC: bank and response written together.
          if (cnt_q <= 3'd1) begin
            cnt_q         <= '0;
            acc_q[bank_q] <= mac_acc_d;
            rsp_data_q    <= mac_acc_d;
            rsp_valid_q   <= 1'b1;
            state_q       <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready             = cmd_ready_q;
  assign rsp_valid             = rsp_valid_q;
  assign rsp_payload_outputs_0 = rsp_data_q;

endmodule

// File: doc/cfu_simd_mac.md
# cfu_simd_mac

Parametrised custom-function unit for the CPU's CFU port. It executes packed 4-lane int8 multiply-accumulate with a programmable input offset into a bank of `NUM_ACC` 32-bit accumulators through a pipelined MAC of configurable depth. It succeeds the fixed single-engine conv1d CFU: it adds multi-cycle commands, explicit busy back-pressure, bank selection via funct3, and accumulator preload/readback. It sits directly on the CPU CFU bus and replaces the `Cfu` top in conv-heavy builds.

## Interface
- `NUM_ACC`, default 4, meaning number of accumulator banks; power of two, 1..8.
- `MAC_STAGES`, default 2, meaning MAC pipeline depth in cycles; range 1..4.
- `OFFSET_W`, default 9, meaning signed input-offset width.

- `clk` input 1: the single clock.
- `reset` input 1: synchronous, active-high.
- `cmd_valid` input 1: command offered.
- `cmd_ready` output 1: command accepted when high together with `cmd_valid`.
- `cmd_payload_function_id` input 10: bits [9:3] are funct7 (opcode); bits [2:0] are funct3 (bank select).
- `cmd_payload_inputs_0` input 32: operand A (packed int8 activations, or a value).
- `cmd_payload_inputs_1` input 32: operand B (packed int8 weights).
- `rsp_valid` output 1: response available.
- `rsp_ready` input 1: CPU consumes the response.
- `rsp_payload_outputs_0` output 32: response data.

## Operation
- The bank index is `funct3 mod NUM_ACC`, and it is latched at accept.
- funct7 0, ECHO: response is `inputs_0`.
- funct7 1, SET_OFFSET: `offset <= inputs_0[OFFSET_W-1:0]` (signed). Response is 0.
- funct7 2, CLEAR: `acc[bank] <= 0`. Response is the previous value.
- funct7 3, MAC: for lanes i=0..3, `a_i = sext(inputs_0[8i+7:8i]) + offset` (9-bit signed) and `b_i = sext(inputs_1[8i+7:8i])`. Each product `a_i*b_i` is 17-bit signed. The lane sum is 19-bit signed and sign-extended to 32 bits. `acc[bank] <= acc[bank] + sum`, with two's-complement wrap and no saturation. Response is the new accumulator value.
- funct7 4, READ: response is `acc[bank]`.
- funct7 5, SET_ACC: `acc[bank] <= inputs_0`. Response is `inputs_0`.
- Any other funct7: no state change. Response is 0.
- FSM states are IDLE, BUSY and RESP.
  - IDLE: `cmd_ready`=1. On accept, MAC goes to BUSY; every other opcode goes to RESP with its result registered.
  - BUSY: `cmd_ready`=0. A counter runs from `MAC_STAGES` down to 0. At 0, the accumulator and the response register are written in the same cycle, then the FSM goes to RESP.
  - RESP: `rsp_valid`=1 and `cmd_ready`=0. `rsp_payload_outputs_0` is held stable. When `rsp_ready`=1 the FSM returns to IDLE on the next edge.
- Only one command is outstanding at a time, so there are no read-after-write hazards between banks.
- Operands and offset are latched at accept. Later bus changes have no effect.

## Timing
- Reset values:
  - `rsp_valid`=0, `cmd_ready`=1 (IDLE), `rsp_payload_outputs_0`=0.
  - All accumulators are 0, `offset` is 0, the counter is 0.
- Reset asserted in any state forces IDLE on the next edge. An in-flight MAC is discarded and a pending response is dropped.
- Latency from the accept edge to the first `rsp_valid`=1 cycle:
  - Non-MAC opcodes: 1 cycle.
  - MAC: `MAC_STAGES`+1 cycles.
- A response consumed when `rsp_ready`=1 in the first RESP cycle allows the next accept 1 cycle later. Minimum throughput is therefore 2 cycles per non-MAC command and `MAC_STAGES`+2 cycles per MAC.
- `rsp_ready` held low keeps RESP indefinitely, with output data unchanged.
- `cmd_valid` while `cmd_ready`=0 is ignored; there is no queuing.
- `rsp_ready` asserted outside RESP has no effect.
- SET_OFFSET takes effect for MACs accepted after its response is consumed.

## Test plan
- Reset, then ECHO 0x12345678 → `rsp_valid` 1 cycle after accept, data 0x12345678. `cmd_ready`=0 until `rsp_ready` is seen.
- Offset 0, bank 1, MAC with inputs_0=0x01020304 and inputs_1=0x01010101 → response 10 after `MAC_STAGES`+1 cycles. A following READ of bank 1 returns 10 and READ of bank 0 returns 0.
- SET_OFFSET 128, then MAC with inputs_0=0x80808080 and inputs_1=0x7F7F7F7F → response 0. Then MAC with inputs_0=0x01020304 and inputs_1=0x01010101 → response 522.
- SET_ACC bank 2 to 0x7FFFFFFF, offset 0, MAC with inputs_0=0xFFFFFFFF and inputs_1=0xFFFFFFFF → +4 gives 0x80000003 (wrap). CLEAR bank 2 returns 0x80000003, then READ returns 0.
- Hold `rsp_ready`=0 for 10 cycles during a MAC response while toggling `cmd_valid` and operands → data stable and no extra accept. Assert `reset` in a BUSY cycle → next cycle is IDLE, all accumulators 0, no response.
- With funct3=6 and `NUM_ACC`=4, MAC then READ funct3=2 → same bank, value equal. Opcode 0x55 → response 0 and no state change.
